// File: rtl/serial_adder_n.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock, LSB first, with start/busy/done
// handshake and registered sum, carry-out and signed overflow.
module serial_adder_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic             cin_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder_n: WIDTH must be >= 2 and divisible by DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] b_eff;
  logic [DIGIT:0]   slice_full;
  logic [WIDTH-1:0] slice_ext;
  logic [WIDTH-1:0] acc_shift;

  assign b_eff = sub_i ? ~b_i : b_i;

  // One digit per cycle: the new slice enters at the top of the accumulator so that after N
  // shifts the first slice has arrived at bit 0.
  always_comb begin
    slice_full = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    slice_ext  = '0;
    slice_ext[DIGIT-1:0] = slice_full[DIGIT-1:0];
    acc_shift  = (acc_q >> DIGIT) | (slice_ext << (WIDTH - DIGIT));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d = StRun;
          a_d     = a_i;
          b_d     = b_eff;
          carry_d = sub_i | cin_i;
          sa_d    = a_i[WIDTH-1];
          sb_d    = b_eff[WIDTH-1];
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = slice_full[DIGIT];
        acc_d   = acc_shift;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StDone;
          sum_d   = acc_shift;
          cout_d  = slice_full[DIGIT];
          ovf_d   = (sa_q == sb_q) && (acc_shift[WIDTH-1] != sa_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: an 8-bit/1-bit-digit instance and a 16-bit/4-bit-digit instance
// checked against an arithmetic reference model.
module tb_serial_adder_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       st8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic        st16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(st8), .sub_i(sub8), .cin_i(cin8), .a_i(a8), .b_i(b8),
    .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8), .ovf_o(ovf8)
  );

  serial_adder_n #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start_i(st16), .sub_i(sub16), .cin_i(cin16), .a_i(a16),
    .b_i(b16), .busy_o(busy16), .done_o(done16), .sum_o(sum16), .cout_o(cout16), .ovf_o(ovf16)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on a w-bit word.
  task automatic ref_add(input int w, input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic c, output logic [15:0] sum, output logic co,
                         output logic ov);
    int unsigned mask, beff, full;
    mask = (32'd1 << w) - 1;
    beff = (s ? ~{16'h0, b} : {16'h0, b}) & mask;
    full = {16'h0, a} + beff + (s ? 32'd1 : {31'd0, c});
    sum  = 16'(full & mask);
    co   = full[w];
    ov   = (a[w-1] == beff[w-1]) && (sum[w-1] != a[w-1]);
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c);
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; cin8 = c; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
  endtask

  task automatic wait_done8(input int e0, output int edges);
    edges = e0;
    while (!done8 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic expect8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic c);
    logic [15:0] es;
    logic eco, eov;
    ref_add(8, {8'h0, a}, {8'h0, b}, s, c, es, eco, eov);
    check_eq({tag, "_sum"}, {24'h0, sum8}, {16'h0, es});
    check_eq({tag, "_cout"}, {31'h0, cout8}, {31'h0, eco});
    check_eq({tag, "_ovf"}, {31'h0, ovf8}, {31'h0, eov});
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic c);
    int e;
    start8(a, b, s, c);
    check_eq({tag, "_busy"}, {31'h0, busy8}, 32'h1);
    wait_done8(1, e);
    check_eq({tag, "_lat"}, e, 9);
    expect8(tag, a, b, s, c);
    @(posedge clk); #1;
    check_eq({tag, "_done_pulse"}, {31'h0, done8}, 32'h0);
  endtask

  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic c);
    int e;
    logic [15:0] es;
    logic eco, eov;
    @(negedge clk);
    a16 = a; b16 = b; sub16 = s; cin16 = c; st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    a16 = $urandom; b16 = $urandom; sub16 = $urandom; cin16 = $urandom;
    e = 1;
    while (!done16 && e < 40) begin
      @(posedge clk); #1;
      e++;
    end
    ref_add(16, a, b, s, c, es, eco, eov);
    check_eq({tag, "_lat"}, e, 5);
    check_eq({tag, "_sum"}, {16'h0, sum16}, {16'h0, es});
    check_eq({tag, "_cout"}, {31'h0, cout16}, {31'h0, eco});
    check_eq({tag, "_ovf"}, {31'h0, ovf16}, {31'h0, eov});
  endtask

  initial begin
    int e;
    int done_seen;
    logic [15:0] corners [3];
    corners[0] = 16'h0000; corners[1] = 16'hFFFF; corners[2] = 16'h8000;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy8", {31'h0, busy8}, 32'h0);
    check_eq("rst_done8", {31'h0, done8}, 32'h0);
    check_eq("rst_out8", {22'h0, ovf8, cout8, sum8}, 32'h0);
    check_eq("rst_out16", {13'h0, busy16, done16, ovf16, cout16, sum16}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic cases with literal expectations
    start8(8'h0F, 8'h01, 1'b0, 1'b0);
    wait_done8(1, e);
    check_eq("t1_lat", e, 9);
    check_eq("t1_res", {22'h0, ovf8, cout8, sum8}, {22'h0, 1'b0, 1'b0, 8'h10});
    op8("t2a", 8'hFF, 8'h01, 1'b0, 1'b1);
    check_eq("t2a_lit", {22'h0, ovf8, cout8, sum8}, {22'h0, 1'b0, 1'b1, 8'h01});
    op8("t2b", 8'h7F, 8'h01, 1'b0, 1'b0);
    check_eq("t2b_lit", {22'h0, ovf8, cout8, sum8}, {22'h0, 1'b1, 1'b0, 8'h80});
    op8("t3a", 8'h05, 8'h07, 1'b1, 1'b0);
    check_eq("t3a_lit", {22'h0, ovf8, cout8, sum8}, {22'h0, 1'b0, 1'b0, 8'hFE});
    op8("t3b", 8'h80, 8'h01, 1'b1, 1'b1);
    check_eq("t3b_lit", {22'h0, ovf8, cout8, sum8}, {22'h0, 1'b1, 1'b1, 8'h7F});

    // Start while busy is ignored; start in the done cycle is accepted
    start8(8'h12, 8'h34, 1'b0, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1; cin8 = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    check_eq("t4_busy_ign", {31'h0, busy8}, 32'h1);
    wait_done8(4, e);
    check_eq("t4_lat", e, 9);
    check_eq("t4_res", {22'h0, ovf8, cout8, sum8}, {22'h0, 1'b0, 1'b0, 8'h47});
    @(negedge clk);
    check_eq("t4_done_held", {31'h0, done8}, 32'h1);
    a8 = 8'hC8; b8 = 8'h64; sub8 = 1'b1; cin8 = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    check_eq("t4_b2b_nolap", {30'h0, busy8, done8}, 32'h2);
    check_eq("t4_sum_held", {24'h0, sum8}, 32'h47);
    wait_done8(1, e);
    check_eq("t4_b2b_lat", e, 9);
    expect8("t4_b2b", 8'hC8, 8'h64, 1'b1, 1'b0);

    // Reset in the middle of a run aborts it
    start8(8'h3C, 8'h42, 1'b0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_busy", {31'h0, busy8}, 32'h0);
    check_eq("t5_rst_out", {22'h0, ovf8, cout8, sum8}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) done_seen++;
    end
    check_eq("t5_no_done", done_seen, 0);
    op8("t5_after", 8'h3C, 8'h42, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      op8("rnd8", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        for (int s = 0; s < 2; s++) begin
          op16("c16", corners[i], corners[j], s[0], 1'($urandom));
        end
      end
    end
    for (int i = 0; i < 20; i++) begin
      op16("rnd16", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
